// File: rtl/clock_enable_gen.sv
// Multi-channel programmable clock-enable generator: each channel emits a one-cycle
// enable every R+1 cycles (continuous) or once per run assertion (one-shot).

module clock_enable_ch #(
  parameter int CNT_W         = 16,
  parameter int DEFAULT_RATIO = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we_i,
  input  logic [CNT_W-1:0] cfg_ratio_i,
  input  logic             cfg_oneshot_i,
  input  logic             run_i,
  input  logic             sync_i,
  output logic             en_o,
  output logic             busy_o
);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  localparam logic [CNT_W-1:0] RATIO_RST = CNT_W'(DEFAULT_RATIO);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ratio_q, ratio_d;
  logic [CNT_W-1:0] sh_ratio_q, sh_ratio_d;
  logic             oneshot_q, oneshot_d;
  logic             sh_oneshot_q, sh_oneshot_d;
  logic             pend_q, pend_d;
  logic             en_q, en_d;
  logic             apply;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ratio_q      <= RATIO_RST;
      sh_ratio_q   <= RATIO_RST;
      oneshot_q    <= 1'b0;
      sh_oneshot_q <= 1'b0;
      pend_q       <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ratio_q      <= ratio_d;
      sh_ratio_q   <= sh_ratio_d;
      oneshot_q    <= oneshot_d;
      sh_oneshot_q <= sh_oneshot_d;
      pend_q       <= pend_d;
      en_q         <= en_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ratio_d      = ratio_q;
    sh_ratio_d   = sh_ratio_q;
    oneshot_d    = oneshot_q;
    sh_oneshot_d = sh_oneshot_q;
    pend_d       = pend_q;
    en_d         = 1'b0;
    apply        = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        apply = pend_q;
        if (run_i) state_d = COUNT;
      end
      COUNT: begin
        if (!run_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sync_i) begin
          // realign: behaves as a wrap for shadow apply, but never pulses or completes a one-shot
          cnt_d = '0;
          apply = pend_q;
        end else if (cnt_q == ratio_q) begin
          cnt_d = '0;
          en_d  = 1'b1;
          apply = pend_q;
          if (oneshot_q) state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        cnt_d = '0;
        apply = pend_q;
        if (!run_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (apply) begin
      ratio_d   = sh_ratio_q;
      oneshot_d = sh_oneshot_q;
      pend_d    = 1'b0;
    end
    // a write on the apply edge lands after the old shadow has been consumed
    if (cfg_we_i) begin
      sh_ratio_d   = cfg_ratio_i;
      sh_oneshot_d = cfg_oneshot_i;
      pend_d       = 1'b1;
    end
  end

  assign en_o   = en_q;
  assign busy_o = (state_q == COUNT);
endmodule

module clock_enable_gen #(
  parameter  int CHANNELS      = 4,
  parameter  int CNT_W         = 16,
  parameter  int DEFAULT_RATIO = 50,
  localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_ratio,
  input  logic                cfg_oneshot,
  input  logic [CHANNELS-1:0] run,
  input  logic                sync,
  output logic [CHANNELS-1:0] o_en,
  output logic [CHANNELS-1:0] o_busy
);
  logic                turn_q, turn_d;
  logic                cfg_acc;
  logic [CHANNELS-1:0] cfg_we;

  assign cfg_ready = !rst && !turn_q;
  assign cfg_acc   = cfg_valid && cfg_ready;
  assign turn_d    = cfg_acc;

  always_ff @(posedge clk) begin
    if (rst) turn_q <= 1'b0;
    else     turn_q <= turn_d;
  end

  // out-of-range channel numbers decode to no channel and are silently dropped
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign cfg_we[i] = cfg_acc && (cfg_ch == CH_W'(i));
    clock_enable_ch #(
      .CNT_W        (CNT_W),
      .DEFAULT_RATIO(DEFAULT_RATIO)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .cfg_we_i     (cfg_we[i]),
      .cfg_ratio_i  (cfg_ratio),
      .cfg_oneshot_i(cfg_oneshot),
      .run_i        (run[i]),
      .sync_i       (sync),
      .en_o         (o_en[i]),
      .busy_o       (o_busy[i])
    );
  end
endmodule
